// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word/register types, ALU opcodes, forwarding selects,
// and the latched ID/EX record used by id_ex_stage.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    logic     regwrite;
    logic     memread;
    logic     alusrc;
    logic     shift;
    aluop_t   aluop;
    regbits_t rs;
    regbits_t rt;
    regbits_t dest;
    regbits_t shamt;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic word_t fwd_mux(fwd_sel_t sel, word_t lat, word_t exmem, word_t memwb);
    case (sel)
      FWD_EXMEM: fwd_mux = exmem;
      FWD_MEMWB: fwd_mux = memwb;
      default:   fwd_mux = lat;
    endcase
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding-source selection for the latched rs and rt indices.
// Register 0 never forwards; EX/MEM takes precedence over MEM/WB.
module forward_unit
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             exmem_regwrite_i,
  input  logic [REG_W-1:0] exmem_dest_i,
  input  logic             memwb_regwrite_i,
  input  logic [REG_W-1:0] memwb_dest_i,
  output fwd_sel_t         rs_sel_o,
  output fwd_sel_t         rt_sel_o
);

  logic [1:0][REG_W-1:0] src;
  assign src = {rt_i, rs_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    fwd_sel_t sel;
    assign sel = (src[gi] == '0)                                   ? FWD_NONE  :
                 (exmem_regwrite_i && (exmem_dest_i == src[gi]))   ? FWD_EXMEM :
                 (memwb_regwrite_i && (memwb_dest_i == src[gi]))   ? FWD_MEMWB :
                                                                     FWD_NONE;
  end

  assign rs_sel_o = g_src[0].sel;
  assign rt_sel_o = g_src[1].sel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall generation.
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding (load-use stall only).
module id_ex_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  aluop_t            id_aluop,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [WORD_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic              id_shift,
  input  logic [REG_W-1:0]  id_shamt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_dest,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_dest,
  input  logic [WORD_W-1:0] memwb_wdat,
  output aluop_t            aluop,
  output logic [WORD_W-1:0] portA,
  output logic [WORD_W-1:0] portB,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [REG_W-1:0]  ex_dest,
  output logic [WORD_W-1:0] ex_store_data,
  output logic              stall
);

  id_ex_t            ex_q, ex_d;
  fwd_sel_t          sel_rs, sel_rt;
  logic [WORD_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    ex_d = ex_q;
    if (en) begin
      if (flush || stall) begin
        ex_d = ID_EX_BUBBLE;
      end else begin
        ex_d.valid    = id_valid;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_d.alusrc   = id_alusrc;
        ex_d.shift    = id_shift;
        ex_d.aluop    = id_aluop;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.dest     = id_dest;
        ex_d.shamt    = id_shamt;
        ex_d.rdat1    = id_rdat1;
        ex_d.rdat2    = id_rdat2;
        ex_d.imm      = id_imm;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  forward_unit #(.REG_W(REG_W)) u_forward_unit (
    .rs_i             (ex_q.rs),
    .rt_i             (ex_q.rt),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_dest_i     (exmem_dest),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_dest_i     (memwb_dest),
    .rs_sel_o         (sel_rs),
    .rt_sel_o         (sel_rt)
  );

`ifdef ID_EX_FORWARD_EN
  assign fwd_rs = fwd_mux(sel_rs, ex_q.rdat1, exmem_result, memwb_wdat);
  assign fwd_rt = fwd_mux(sel_rt, ex_q.rdat2, exmem_result, memwb_wdat);

  // Only a load in EX cannot be forwarded in time; both sources are compared.
  assign stall = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.dest != '0) &&
                 id_valid && ((id_rs == ex_q.dest) || (id_rt == ex_q.dest));
`else
  logic rs_hit, rt_hit;
  logic unused_fwd;

  assign fwd_rs = ex_q.rdat1;
  assign fwd_rt = ex_q.rdat2;

  // MEM/WB is exempt: the register file writes in the first half-cycle.
  assign rs_hit = (id_rs != '0) &&
                  ((ex_q.valid && ex_q.regwrite && (id_rs == ex_q.dest)) ||
                   (exmem_regwrite && (id_rs == exmem_dest)));
  assign rt_hit = (id_rt != '0) &&
                  ((ex_q.valid && ex_q.regwrite && (id_rt == ex_q.dest)) ||
                   (exmem_regwrite && (id_rt == exmem_dest)));
  assign stall  = id_valid && (rs_hit || rt_hit);

  assign unused_fwd = ^{sel_rs, sel_rt, exmem_result, memwb_wdat};
`endif

  assign aluop         = ex_q.aluop;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_dest       = ex_q.dest;
  assign portA         = ex_q.shift ? fwd_rt : fwd_rs;
  assign portB         = ex_q.shift  ? {{(WORD_W-REG_W){1'b0}}, ex_q.shamt} :
                         ex_q.alusrc ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic, all checked against a behavioural pipeline-slot model.
module tb_id_ex_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, id_valid;
  aluop_t      id_aluop;
  logic [31:0] id_rdat1, id_rdat2, id_imm;
  logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
  logic        id_alusrc, id_shift, id_regwrite, id_memread;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_dest, memwb_dest;
  logic [31:0] exmem_result, memwb_wdat;
  aluop_t      aluop;
  logic [31:0] portA, portB, ex_store_data;
  logic        ex_valid, ex_regwrite, ex_memread, stall;
  logic [4:0]  ex_dest;

  int tests = 0;
  int fails = 0;

  // Model of the instruction currently occupying the EX slot.
  logic        m_valid, m_regwrite, m_memread, m_alusrc, m_shift;
  aluop_t      m_aluop;
  logic [4:0]  m_rs, m_rt, m_dest, m_shamt;
  logic [31:0] m_rdat1, m_rdat2, m_imm;

  always #5 CLK = ~CLK;

  id_ex_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_shift(id_shift), .id_shamt(id_shamt),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_dest(memwb_dest), .memwb_wdat(memwb_wdat),
    .aluop(aluop), .portA(portA), .portB(portB),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_dest(ex_dest), .ex_store_data(ex_store_data), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mfwd(input logic [4:0] src, input logic [31:0] lat);
`ifdef ID_EX_FORWARD_EN
    if (src != 0 && exmem_regwrite && exmem_dest == src) return exmem_result;
    if (src != 0 && memwb_regwrite && memwb_dest == src) return memwb_wdat;
`endif
    return lat;
  endfunction

  function automatic logic mstall();
`ifdef ID_EX_FORWARD_EN
    return m_valid && m_memread && m_regwrite && m_dest != 0 && id_valid &&
           (id_rs == m_dest || id_rt == m_dest);
`else
    logic       hit;
    logic [4:0] src;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      src = (k == 0) ? id_rs : id_rt;
      if (src != 0 && ((m_valid && m_regwrite && src == m_dest) ||
                       (exmem_regwrite && src == exmem_dest)))
        hit = 1'b1;
    end
    return id_valid && hit;
`endif
  endfunction

  task automatic model_clear();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_alusrc = 0; m_shift = 0;
    m_aluop = ALU_SLL; m_rs = 0; m_rt = 0; m_dest = 0; m_shamt = 0;
    m_rdat1 = 0; m_rdat2 = 0; m_imm = 0;
  endtask

  task automatic model_capture();
    m_valid = id_valid; m_regwrite = id_regwrite; m_memread = id_memread;
    m_alusrc = id_alusrc; m_shift = id_shift; m_aluop = id_aluop;
    m_rs = id_rs; m_rt = id_rt; m_dest = id_dest; m_shamt = id_shamt;
    m_rdat1 = id_rdat1; m_rdat2 = id_rdat2; m_imm = id_imm;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_a, exp_b, exp_st;
    exp_st = mfwd(m_rt, m_rdat2);
    exp_a  = m_shift ? exp_st : mfwd(m_rs, m_rdat1);
    exp_b  = m_shift ? {27'b0, m_shamt} : (m_alusrc ? m_imm : exp_st);
    check({tag, ".ex_valid"},    32'(ex_valid),    32'(m_valid));
    check({tag, ".ex_regwrite"}, 32'(ex_regwrite), 32'(m_regwrite));
    check({tag, ".ex_memread"},  32'(ex_memread),  32'(m_memread));
    check({tag, ".ex_dest"},     32'(ex_dest),     32'(m_dest));
    check({tag, ".aluop"},       32'(aluop),       32'(m_aluop));
    check({tag, ".portA"},       portA,            exp_a);
    check({tag, ".portB"},       portB,            exp_b);
    check({tag, ".store"},       ex_store_data,    exp_st);
    check({tag, ".stall"},       32'(stall),       32'(nRST ? mstall() : 1'b0));
  endtask

  // Inputs are set just after a rising edge; this checks stall, clocks once, then checks the slot.
  task automatic step(input string tag);
    logic s;
    #1;
    s = mstall();
    check({tag, ".stall_pre"}, 32'(stall), 32'(s));
    @(posedge CLK);
    if (nRST && en) begin
      if (flush || s) model_clear();
      else            model_capture();
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_instr(input logic v, input aluop_t op, input logic [4:0] rs, rt, dst,
                           input logic [31:0] r1, r2, imm, input logic asrc, sh,
                           input logic [4:0] shamt, input logic rw, mr);
    id_valid = v; id_aluop = op; id_rs = rs; id_rt = rt; id_dest = dst;
    id_rdat1 = r1; id_rdat2 = r2; id_imm = imm; id_alusrc = asrc; id_shift = sh;
    id_shamt = shamt; id_regwrite = rw; id_memread = mr;
  endtask

  initial begin
    nRST = 0; en = 1; flush = 0;
    exmem_regwrite = 0; exmem_dest = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_dest = 0; memwb_wdat = 0;
    set_instr(1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'h33, 1, 1, 5'd4, 1, 1);
    model_clear();

    // Reset holds everything at zero even with a live instruction and en=1.
    repeat (3) @(posedge CLK);
    #1;
    check_all("reset");
    check("reset.portA_zero", portA, 32'h0);

    nRST = 1;
    step("first_latch");
    check("first_latch.valid", 32'(ex_valid), 32'h1);

    set_instr(0, ALU_SLL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("drain");

`ifdef ID_EX_FORWARD_EN
    // ADD $3,$1,$2 then SUB $4,$3,$1 with ADD's result forwarded from EX/MEM.
    set_instr(1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 0, 0, 0, 0, 1, 0);
    step("add3");
    set_instr(1, ALU_SUB, 5'd3, 5'd1, 5'd4, 32'h99, 32'h5, 0, 0, 0, 0, 1, 0);
    step("sub4");
    exmem_regwrite = 1; exmem_dest = 5'd3; exmem_result = 32'h10;
    #1;
    check("fwd_exmem.portA", portA, 32'h10);
    check("fwd_exmem.aluop", 32'(aluop), 32'(ALU_SUB));

    // EX/MEM wins over MEM/WB for the same register.
    set_instr(1, ALU_ADD, 5'd5, 5'd0, 5'd6, 32'h1, 32'h0, 0, 0, 0, 0, 1, 0);
    step("dbl");
    exmem_regwrite = 1; exmem_dest = 5'd5; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_dest = 5'd5; memwb_wdat = 32'hBB;
    #1;
    check("fwd_double.portA", portA, 32'hAA);

    // LW $7 then ADD $8,$7,$7: exactly one bubble, then MEM/WB data on both ports.
    exmem_regwrite = 0; memwb_regwrite = 0;
    set_instr(1, ALU_ADD, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h4, 1, 0, 0, 1, 1);
    step("lw7");
    set_instr(1, ALU_ADD, 5'd7, 5'd7, 5'd8, 32'h1, 32'h1, 0, 0, 0, 0, 1, 0);
    #1;
    check("loaduse.stall", 32'(stall), 32'h1);
    step("loaduse.bubble");
    check("loaduse.ex_valid", 32'(ex_valid), 32'h0);
    exmem_regwrite = 1; exmem_dest = 5'd7; exmem_result = 32'h104;
    #1;
    check("loaduse.stall_clear", 32'(stall), 32'h0);
    step("loaduse.add8");
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_dest = 5'd7; memwb_wdat = 32'hCAFE;
    #1;
    check("loaduse.portA", portA, 32'hCAFE);
    check("loaduse.portB", portB, 32'hCAFE);

    // Register 0 never forwards.
    memwb_regwrite = 0;
    set_instr(1, ALU_OR, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
    exmem_regwrite = 1; exmem_dest = 5'd0; exmem_result = 32'hDEAD;
    step("zero_reg");
    check("zero_reg.portA", portA, 32'h0);
    exmem_regwrite = 0;
`else
    // ADD $3 then OR $9,$3,$0: two stall cycles (EX, then EX/MEM), then latched data.
    set_instr(1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 0, 0, 0, 0, 1, 0);
    step("nf_add3");
    set_instr(1, ALU_OR, 5'd3, 5'd0, 5'd9, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
    #1;
    check("nf.stall_a", 32'(stall), 32'h1);
    step("nf_bubble_a");
    exmem_regwrite = 1; exmem_dest = 5'd3; exmem_result = 32'hB;
    #1;
    check("nf.stall_b", 32'(stall), 32'h1);
    step("nf_bubble_b");
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_dest = 5'd3; memwb_wdat = 32'hB;
    id_rdat1 = 32'hB;
    #1;
    check("nf.stall_c", 32'(stall), 32'h0);
    step("nf_or9");
    check("nf.portA", portA, 32'hB);
    check("nf.aluop", 32'(aluop), 32'(ALU_OR));
    memwb_regwrite = 0;
`endif

    // Flush loads a bubble even for a valid instruction.
    set_instr(1, ALU_XOR, 5'd10, 5'd11, 5'd12, 32'h7, 32'h8, 0, 0, 0, 0, 1, 0);
    flush = 1;
    step("flush");
    check("flush.ex_valid", 32'(ex_valid), 32'h0);
    flush = 0;

    // en=0 holds the slot while ID inputs change.
    step("capture12");
    en = 0;
    set_instr(1, ALU_NOR, 5'd13, 5'd14, 5'd15, 32'h9, 32'hA, 0, 0, 0, 0, 1, 0);
    step("hold");
    check("hold.ex_dest", 32'(ex_dest), 32'd12);
    en = 1;

    // Stall, then reset mid-cycle drops both the bubble and the held instruction.
    set_instr(1, ALU_ADD, 5'd1, 5'd0, 5'd20, 32'h40, 32'h0, 32'h8, 1, 0, 0, 1, 1);
    step("lw20");
    set_instr(1, ALU_ADD, 5'd20, 5'd2, 5'd21, 32'h1, 32'h2, 0, 0, 0, 0, 1, 0);
    #1;
    check("midrst.stall", 32'(stall), 32'h1);
    nRST = 0;
    #1;
    model_clear();
    check_all("midrst");
    nRST = 1;
    @(posedge CLK);
    if (mstall()) model_clear(); else model_capture();
    #1;
    check_all("after_rst");

    // Randomized traffic with a small register range to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 9) == 0);
      set_instr($urandom_range(0, 3) != 0, aluop_t'($urandom_range(0, 9)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom, 1'($urandom), ($urandom_range(0, 5) == 0),
                5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      exmem_regwrite = 1'($urandom); exmem_dest = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_dest = 5'($urandom_range(0, 7)); memwb_wdat = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage for the 5-stage MIPS pipeline.
- Latches decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a one-cycle bubble.
- Drives aluop/portA/portB directly into the ALU interface.

Parameters:
- WORD_W, 32, datapath width
- REG_W, 5, register-index width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- en  in  1  pipeline advance (global hit); 0 holds all state
- flush  in  1  squash: load bubble on next advancing edge
- id_valid  in  1  ID slot holds a real instruction
- id_aluop  in  aluop_t  decoded ALU operation
- id_rdat1, id_rdat2  in  WORD_W  register-file read data (rs, rt)
- id_rs, id_rt, id_dest  in  REG_W  source and destination indices
- id_imm  in  WORD_W  extended immediate
- id_alusrc  in  1  portB = imm (1) or rt (0)
- id_shift  in  1  shift op: portA = rt, portB = shamt
- id_shamt  in  REG_W  shift amount
- id_regwrite, id_memread  in  1  writeback enable; instruction is a load
- exmem_regwrite  in  1  EX/MEM writes a register
- exmem_dest  in  REG_W  EX/MEM destination index
- exmem_result  in  WORD_W  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB writes a register
- memwb_dest  in  REG_W  MEM/WB destination index
- memwb_wdat  in  WORD_W  MEM/WB writeback data
- aluop  out  aluop_t  to ALU
- portA, portB  out  WORD_W  to ALU
- ex_valid, ex_regwrite, ex_memread  out  1  registered control into EX
- ex_dest  out  REG_W  registered destination index
- ex_store_data  out  WORD_W  forwarded rt value for stores
- stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (nRST low, asynchronous):
  - All registers clear to 0.
  - ex_valid = ex_regwrite = ex_memread = 0, aluop = ALU_SLL (encoding 0).
  - portA = portB = ex_store_data = 0.
  - stall = 0.
  - Reset mid-stall drops the bubble and the held instruction.
- Edge update priority:
  - en=0: hold everything.
  - en=1 and flush: load bubble.
  - en=1 and stall: load bubble.
  - Otherwise: capture all id_* fields; ex_valid = id_valid.
- Bubble: valid, regwrite and memread = 0; data fields are don't-care but cleared to 0.
- Latency: one cycle from ID capture to ALU operands.
- Load-use stall is combinational: stall = ex_valid & ex_memread & ex_regwrite & ex_dest!=0 & id_valid & (id_rs==ex_dest | id_rt==ex_dest).
  - The compare is conservative: it checks both sources regardless of use.
  - At most one bubble per load; the next cycle the load sits in MEM, so stall deasserts.
- Forwarding select per latched source (rs and rt separately), combinational on registered indices:
  - EX/MEM if exmem_regwrite & exmem_dest==src & src!=0.
  - Else MEM/WB if memwb_regwrite & memwb_dest==src & src!=0.
  - Else latched register-file data.
  - EX/MEM wins when both match. Register 0 always reads the latched value.
- Operand muxing:
  - portA = id_shift ? fwd_rt : fwd_rs.
  - portB = id_shift ? zero-extended shamt : (alusrc ? imm : fwd_rt).
  - ex_store_data = fwd_rt.
- Outputs hold stable while en=0, but forwarding tracks live EX/MEM and MEM/WB inputs.

Optional Feature:
- ID_EX_FORWARD_EN defined:
  - Forwarding as above; stall only on load-use.
- Not defined:
  - No forwarding; operands always come from latched data.
  - stall asserts whenever id_valid and id_rs or id_rt (nonzero) matches ex_dest (ex_valid & ex_regwrite) or exmem_dest (exmem_regwrite).
  - The register file writes in the first half-cycle, so MEM/WB needs no stall.

Decomposition:
- Add to cpu_types_pkg:
  - fwd_sel_t enum: FWD_NONE, FWD_EXMEM, FWD_MEMWB.
  - An id_ex_t packed struct holding the latched fields.
  - Reuse the existing word_t, regbits_t and aluop_t.
- Sub-module forward_unit: combinational select generation for rs and rt, instantiated once.

Test Plan:
- Reset: nRST low, drive nonzero id_* and en=1 → all outputs 0, stall=0. Release nRST → first edge latches.
- ADD $3,$1,$2 then SUB $4,$3,$1, with exmem_dest=3 and exmem_result=0x10 → second op portA=0x10; aluop=ALU_SUB.
- Double hazard: exmem_dest=5 (0xAA) and memwb_dest=5 (0xBB), rs=5 → portA=0xAA.
- LW $7 then ADD $8,$7,$7 → stall=1 for exactly one cycle, ex_valid=0 next cycle. ADD then gets memwb_wdat on both ports.
- $0 hazard: exmem_dest=0, exmem_regwrite=1, id_rs=0 → portA=0. Separately, flush+stall with en=1 → bubble; en=0 → all outputs held.
- ID_EX_FORWARD_EN undefined: ADD $3 then OR using $3 → stall=1 for two cycles, then the OR reads the latched register-file value.
